// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic sequencer.
//   state_e        sequencer FSM states
//   ADDR_*         ld_addr map of the operand register file (A tile 0..3, B tile 4..7)
//   SLOT_* and res_lsb()  placement of each 2*WIDTH result inside the packed res_c bundle
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FEED0 = 3'd2,
    ST_FEED1 = 3'd3,
    ST_FEED2 = 3'd4,
    ST_DRAIN = 3'd5,
    ST_RESP  = 3'd6
  } state_e;

  localparam logic [2:0] ADDR_A00 = 3'd0;
  localparam logic [2:0] ADDR_A01 = 3'd1;
  localparam logic [2:0] ADDR_A10 = 3'd2;
  localparam logic [2:0] ADDR_A11 = 3'd3;
  localparam logic [2:0] ADDR_B00 = 3'd4;
  localparam logic [2:0] ADDR_B01 = 3'd5;
  localparam logic [2:0] ADDR_B10 = 3'd6;
  localparam logic [2:0] ADDR_B11 = 3'd7;

  localparam int SLOT_C00 = 0;
  localparam int SLOT_C01 = 1;
  localparam int SLOT_C10 = 2;
  localparam int SLOT_C11 = 3;

  // LSB of a result slot in the {c11,c10,c01,c00} bundle.
  function automatic int res_lsb(input int slot, input int width);
    return slot * 2 * width;
  endfunction

endpackage

// File: rtl/sys_operand_rf.sv
// Operand register file: 8 entries of WIDTH bits, one write port, every entry
// exposed on a flat bus (entry n at rf_q[n*WIDTH +: WIDTH]).
//   clk, rst   clock, asynchronous active-high reset (all entries cleared)
//   wr_en      write strobe
//   wr_addr    entry to write (0..7)
//   wr_data    value written
//   rf_q       all entries, flop outputs
module sys_operand_rf #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  output logic [8*WIDTH-1:0] rf_q
);

  logic [8*WIDTH-1:0] rf_d;

  always_comb begin
    rf_d = rf_q;
    if (wr_en) begin
      rf_d[int'(wr_addr)*WIDTH +: WIDTH] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

endmodule

// File: rtl/systolic_seq_2x2.sv
// Sequencer for the 2x2 systolic array: buffers one A and one B tile, clears the
// array, feeds operands with diagonal skew, waits for the array to drain, captures
// the four results and offers them on a valid/ready port.
// Optional feature macro: SYS_ACCUM_EN -- when defined, start with accum=1 skips the
// array clear so results accumulate onto the previous run.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ld_valid/ld_ready/ld_addr/ld_data   byte-wide operand load port
//   start, accum                  run request (sampled in IDLE only)
//   busy                          high outside IDLE
//   arr_clear, arr_a0/a1/b0/b1    drive the array
//   arr_c00..arr_c11              array results
//   res_valid/res_ready/res_c     result bundle {c11,c10,c01,c00}
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | loads accepted, waiting for start
// CLR      | one cycle: clear the array (unless accumulating)
// FEED0..2 | skewed operand wavefronts into the array
// DRAIN    | array pipeline settles; capture results at terminal count
// RESP     | res_valid held until res_ready
module systolic_seq_2x2
  import systolic_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [2:0]         ld_addr,
  input  logic [WIDTH-1:0]   ld_data,
  input  logic               start,
  input  logic               accum,
  output logic               busy,
  output logic               arr_clear,
  output logic [WIDTH-1:0]   arr_a0,
  output logic [WIDTH-1:0]   arr_a1,
  output logic [WIDTH-1:0]   arr_b0,
  output logic [WIDTH-1:0]   arr_b1,
  input  logic [2*WIDTH-1:0] arr_c00,
  input  logic [2*WIDTH-1:0] arr_c01,
  input  logic [2*WIDTH-1:0] arr_c10,
  input  logic [2*WIDTH-1:0] arr_c11,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [8*WIDTH-1:0] res_c
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  // The counter runs DRAIN_CYCLES..0: the last feed wavefront is only registered
  // into the array at the end of FEED2, so DRAIN_CYCLES full cycles follow that
  // before the capture edge (res_valid at start edge + 5 + DRAIN_CYCLES).
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [8*WIDTH-1:0] res_c_q, res_c_d;
  logic               rdy_en_q, rdy_en_d;
  logic               clear_en;
  logic [8*WIDTH-1:0] rf_q;
  logic               ld_fire;

  assign ld_ready = rdy_en_q & (state_q == ST_IDLE) & ~start;
  assign ld_fire  = ld_valid & ld_ready;

  sys_operand_rf #(.WIDTH(WIDTH)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ld_fire),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rf_q    (rf_q)
  );

  logic [WIDTH-1:0] op_a00, op_a01, op_a10, op_a11;
  logic [WIDTH-1:0] op_b00, op_b01, op_b10, op_b11;

  assign op_a00 = rf_q[int'(ADDR_A00)*WIDTH +: WIDTH];
  assign op_a01 = rf_q[int'(ADDR_A01)*WIDTH +: WIDTH];
  assign op_a10 = rf_q[int'(ADDR_A10)*WIDTH +: WIDTH];
  assign op_a11 = rf_q[int'(ADDR_A11)*WIDTH +: WIDTH];
  assign op_b00 = rf_q[int'(ADDR_B00)*WIDTH +: WIDTH];
  assign op_b01 = rf_q[int'(ADDR_B01)*WIDTH +: WIDTH];
  assign op_b10 = rf_q[int'(ADDR_B10)*WIDTH +: WIDTH];
  assign op_b11 = rf_q[int'(ADDR_B11)*WIDTH +: WIDTH];

`ifdef SYS_ACCUM_EN
  logic accum_q, accum_d;
  assign clear_en = ~accum_q;
`else
  logic accum_unused;
  assign accum_unused = accum;
  assign clear_en     = 1'b1;
`endif

  assign rdy_en_d = 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_c_d = res_c_q;
`ifdef SYS_ACCUM_EN
    accum_d = accum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLR;
`ifdef SYS_ACCUM_EN
          accum_d = accum;
`endif
        end
      end
      ST_CLR:   state_d = ST_FEED0;
      ST_FEED0: state_d = ST_FEED1;
      ST_FEED1: state_d = ST_FEED2;
      ST_FEED2: begin
        state_d = ST_DRAIN;
        cnt_d   = DRAIN_LOAD;
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          res_c_d[res_lsb(SLOT_C00, WIDTH) +: 2*WIDTH] = arr_c00;
          res_c_d[res_lsb(SLOT_C01, WIDTH) +: 2*WIDTH] = arr_c01;
          res_c_d[res_lsb(SLOT_C10, WIDTH) +: 2*WIDTH] = arr_c10;
          res_c_d[res_lsb(SLOT_C11, WIDTH) +: 2*WIDTH] = arr_c11;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Skew mux: row 1 / column 1 lag row 0 / column 0 by one cycle.
  always_comb begin
    arr_clear = 1'b0;
    arr_a0    = '0;
    arr_a1    = '0;
    arr_b0    = '0;
    arr_b1    = '0;
    case (state_q)
      ST_CLR: arr_clear = clear_en;
      ST_FEED0: begin
        arr_a0 = op_a00;
        arr_b0 = op_b00;
      end
      ST_FEED1: begin
        arr_a0 = op_a01;
        arr_a1 = op_a10;
        arr_b0 = op_b10;
        arr_b1 = op_b01;
      end
      ST_FEED2: begin
        arr_a1 = op_a11;
        arr_b1 = op_b11;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_RESP);
  assign res_c     = res_c_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      res_c_q  <= '0;
      rdy_en_q <= 1'b0;
`ifdef SYS_ACCUM_EN
      accum_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_c_q  <= res_c_d;
      rdy_en_q <= rdy_en_d;
`ifdef SYS_ACCUM_EN
      accum_q  <= accum_d;
`endif
    end
  end

endmodule
